// File: rtl/fetch_stage_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_stage_ctrl
//
// Instruction fetch stage controller for an in-order pipeline with a
// synchronous instruction memory (one cycle of read latency).
//
// The PC is presented to memory every cycle. When a fetch is issued, the
// address is tagged into a one-entry in-flight register so that the returning
// data can be paired with its PC in the following cycle. If IF/ID cannot
// accept that response, it is parked in a skid register (state HOLD). Branch
// or jump redirects flush everything in flight and insert one FLUSH cycle.
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   pc_write_i     : hazard unit allows a fetch and a PC advance
//   if_id_write_i  : hazard unit allows IF/ID to update
//   redirect_i     : taken branch/jump pulse from EX
//   redirect_pc_i  : redirect target (forced to word alignment)
//   imem_addr_o    : instruction memory address (current PC)
//   imem_rdata_i   : memory data for the address of the previous cycle
//   if_id_pc_o     : IF/ID PC
//   if_id_instr_o  : IF/ID instruction
//   if_id_valid_o  : IF/ID holds a real instruction (0 = bubble)
//   fetch_hold_o   : skid buffer occupied (state HOLD)
//   state_o        : FSM state, RUN=00 HOLD=01 FLUSH=10
//   stall_cnt_o    : saturating count of stalled cycles
// -----------------------------------------------------------------------------
module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write_i,
    input  logic        if_id_write_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_instr_o,
    output logic        if_id_valid_o,
    output logic        fetch_hold_o,
    output logic [1:0]  state_o,
    output logic [15:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        HOLD  = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic        resp_v, resp_v_next;
    logic [31:0] resp_pc, resp_pc_next;
    logic        resp_parked, resp_parked_next;
    logic [31:0] resp_instr_q, resp_instr_q_next;
    logic [31:0] skid_pc, skid_pc_next;
    logic [31:0] skid_instr, skid_instr_next;
    logic [31:0] if_id_pc_next;
    logic [31:0] if_id_instr_next;
    logic        if_id_valid_next;
    logic        issue;
    logic [31:0] resp_instr;

    assign issue = pc_write_i && !redirect_i && !((state == HOLD) && !if_id_write_i);

    // A response that arrives in HOLD while IF/ID is frozen has nowhere to go
    // (the skid is full), and the memory will not repeat it, so it is parked
    // in the in-flight register with its data until IF/ID moves again.
    assign resp_instr = resp_parked ? resp_instr_q : imem_rdata_i;

    assign imem_addr_o  = pc;
    assign fetch_hold_o = (state == HOLD);
    assign state_o      = state;

    always_comb begin
        state_next        = state;
        pc_next           = pc;
        resp_v_next       = issue;
        resp_pc_next      = pc;
        resp_parked_next  = 1'b0;
        resp_instr_q_next = resp_instr_q;
        skid_pc_next      = skid_pc;
        skid_instr_next   = skid_instr;
        if_id_pc_next     = if_id_pc_o;
        if_id_instr_next  = if_id_instr_o;
        if_id_valid_next  = if_id_valid_o;

        if (issue) begin
            pc_next = pc + 32'd4;
        end

        if (redirect_i) begin
            pc_next          = redirect_pc_i & ~32'h0000_0003;
            if_id_instr_next = NOP_INSTR;
            if_id_valid_next = 1'b0;
            state_next       = FLUSH;
        end else begin
            case (state)
                RUN: begin
                    if (if_id_write_i) begin
                        if (resp_v) begin
                            if_id_pc_next    = resp_pc;
                            if_id_instr_next = resp_instr;
                            if_id_valid_next = 1'b1;
                        end else begin
                            if_id_instr_next = NOP_INSTR;
                            if_id_valid_next = 1'b0;
                        end
                    end else if (resp_v) begin
                        skid_pc_next    = resp_pc;
                        skid_instr_next = resp_instr;
                        state_next      = HOLD;
                    end
                end
                HOLD: begin
                    if (if_id_write_i) begin
                        if_id_pc_next    = skid_pc;
                        if_id_instr_next = skid_instr;
                        if_id_valid_next = 1'b1;
                        if (resp_v) begin
                            skid_pc_next    = resp_pc;
                            skid_instr_next = resp_instr;
                        end else begin
                            state_next = RUN;
                        end
                    end else if (resp_v) begin
                        resp_v_next       = 1'b1;
                        resp_pc_next      = resp_pc;
                        resp_parked_next  = 1'b1;
                        resp_instr_q_next = resp_instr;
                    end
                end
                FLUSH: begin
                    if (if_id_write_i) begin
                        if_id_instr_next = NOP_INSTR;
                        if_id_valid_next = 1'b0;
                    end
                    state_next = RUN;
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= RUN;
            pc            <= RESET_PC;
            resp_v        <= 1'b0;
            resp_pc       <= 32'h0;
            resp_parked   <= 1'b0;
            resp_instr_q  <= 32'h0;
            skid_pc       <= 32'h0;
            skid_instr    <= 32'h0;
            if_id_pc_o    <= 32'h0;
            if_id_instr_o <= NOP_INSTR;
            if_id_valid_o <= 1'b0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            resp_v        <= resp_v_next;
            resp_pc       <= resp_pc_next;
            resp_parked   <= resp_parked_next;
            resp_instr_q  <= resp_instr_q_next;
            skid_pc       <= skid_pc_next;
            skid_instr    <= skid_instr_next;
            if_id_pc_o    <= if_id_pc_next;
            if_id_instr_o <= if_id_instr_next;
            if_id_valid_o <= if_id_valid_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_o <= 16'h0;
        end else if ((!pc_write_i || !if_id_write_i) && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage_ctrl
//
// Testbench for fetch_stage_ctrl. A synchronous memory returns
// address ^ 32'hA5A5_0000 one cycle after the address is presented. The
// reference model treats the fetch stage as an ordered queue of pending
// instructions feeding IF/ID.
// -----------------------------------------------------------------------------
module tb_fetch_stage_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        pc_write;
    logic        if_id_write;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_hold;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: pending instructions in program order, plus the
    // fetch issued in the previous cycle whose data arrives this cycle.
    logic [31:0] m_pc;
    logic [31:0] m_q[$];
    logic        m_arr_v;
    logic [31:0] m_arr_pc;
    logic [31:0] m_ifid_pc;
    logic        m_ifid_valid;
    logic        m_flush;
    logic [15:0] m_stall;

    fetch_stage_ctrl #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pc_write_i   (pc_write),
        .if_id_write_i(if_id_write),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_addr_o  (imem_addr),
        .imem_rdata_i (mem_rdata),
        .if_id_pc_o   (if_id_pc),
        .if_id_instr_o(if_id_instr),
        .if_id_valid_o(if_id_valid),
        .fetch_hold_o (fetch_hold),
        .state_o      (state),
        .stall_cnt_o  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= imem_addr ^ KEY;

    function automatic logic [115:0] dut_vec();
        return {imem_addr, if_id_pc, if_id_instr, if_id_valid, state, fetch_hold, stall_cnt};
    endfunction

    function automatic logic [115:0] model_vec();
        logic [31:0] instr;
        logic [1:0]  st;
        instr = m_ifid_valid ? (m_ifid_pc ^ KEY) : NOP;
        st    = m_flush ? 2'b10 : ((m_q.size() != 0) ? 2'b01 : 2'b00);
        return {m_pc, m_ifid_pc, instr, m_ifid_valid, st, (st == 2'b01), m_stall};
    endfunction

    task automatic model_reset();
        m_pc         = RESET_PC;
        m_q.delete();
        m_arr_v      = 1'b0;
        m_arr_pc     = 32'h0;
        m_ifid_pc    = 32'h0;
        m_ifid_valid = 1'b0;
        m_flush      = 1'b0;
        m_stall      = 16'h0;
    endtask

    task automatic model_clock();
        logic issue;
        if ((!pc_write || !if_id_write) && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
        if (redirect) begin
            m_q.delete();
            m_arr_v      = 1'b0;
            m_ifid_valid = 1'b0;
            m_pc         = {redirect_pc[31:2], 2'b00};
            m_flush      = 1'b1;
        end else begin
            issue = pc_write && !((m_q.size() != 0) && !if_id_write);
            if (if_id_write) begin
                if (m_q.size() != 0) begin
                    m_ifid_pc    = m_q.pop_front();
                    m_ifid_valid = 1'b1;
                    if (m_arr_v) m_q.push_back(m_arr_pc);
                end else if (m_arr_v) begin
                    m_ifid_pc    = m_arr_pc;
                    m_ifid_valid = 1'b1;
                end else begin
                    m_ifid_valid = 1'b0;
                end
            end else if (m_arr_v) begin
                m_q.push_back(m_arr_pc);
            end
            m_arr_v  = issue;
            m_arr_pc = m_pc;
            if (issue) m_pc = m_pc + 32'd4;
            m_flush = 1'b0;
        end
    endtask

    task automatic drive(input logic pw, input logic ifw, input logic rd, input logic [31:0] rpc);
        pc_write    = pw;
        if_id_write = ifw;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_clock();
        #1;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus_free(input int n);
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        logic [115:0] want;
        want = {RESET_PC, 32'h0, NOP, 1'b0, 2'b00, 1'b0, 16'h0};
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        rst_n = 1'b1;
        #2;
        assert_reset();
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("[TB] FAIL reset_async got %h want %h", dut_vec(), want);
        end
        release_reset();
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("[TB] FAIL reset_release got %h want %h", dut_vec(), want);
        end
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc;
        assert_reset();
        release_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 12; i++) begin
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("[TB] FAIL free_run_model cycle %0d got %h want %h", i, dut_vec(), model_vec());
            end
            exp_pc = 32'((i - 1) * 4);
            vectors++;
            if (i == 0) begin
                if (if_id_valid !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL free_run_first_bubble valid got %b want 0", if_id_valid);
                end
            end else if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, exp_pc, exp_pc ^ KEY}) begin
                miscompares++;
                $display("[TB] FAIL free_run_seq cycle %0d got v=%b pc=%h instr=%h want pc=%h",
                         i, if_id_valid, if_id_pc, if_id_instr, exp_pc);
            end
        end
    endtask

    task automatic test_stall_no_issue();
        assert_reset();
        release_reset();
        applyStimulus_free(4);
        vectors++;
        if (imem_addr !== 32'h10) begin
            miscompares++;
            $display("[TB] FAIL stall_pc_at_10 got %h want 00000010", imem_addr);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("[TB] FAIL stall_model cycle %0d got %h want %h", i, dut_vec(), model_vec());
            end
        end
        vectors++;
        if ({state, stall_cnt, imem_addr} !== {2'b01, 16'd2, 32'h10}) begin
            miscompares++;
            $display("[TB] FAIL stall_hold got state=%b cnt=%0d addr=%h want state=01 cnt=2 addr=00000010",
                     state, stall_cnt, imem_addr);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if ({if_id_valid, if_id_pc} !== {1'b1, 32'h0C + 32'(4 * k)}) begin
                miscompares++;
                $display("[TB] FAIL stall_release_order step %0d got v=%b pc=%h want pc=%h",
                         k, if_id_valid, if_id_pc, 32'h0C + 32'(4 * k));
            end
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("[TB] FAIL stall_release_model step %0d got %h want %h", k, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_skid_pc_write();
        assert_reset();
        release_reset();
        applyStimulus_free(4);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("[TB] FAIL skid_model cycle %0d got %h want %h", i, dut_vec(), model_vec());
            end
        end
        vectors++;
        if ({imem_addr, fetch_hold, if_id_pc} !== {32'h14, 1'b1, 32'h08}) begin
            miscompares++;
            $display("[TB] FAIL skid_freeze got addr=%h hold=%b ifid=%h want addr=00000014 hold=1 ifid=00000008",
                     imem_addr, fetch_hold, if_id_pc);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if ({if_id_valid, if_id_pc} !== {1'b1, 32'h0C + 32'(4 * k)}) begin
                miscompares++;
                $display("[TB] FAIL skid_release_order step %0d got v=%b pc=%h want pc=%h",
                         k, if_id_valid, if_id_pc, 32'h0C + 32'(4 * k));
            end
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("[TB] FAIL skid_release_model step %0d got %h want %h", k, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_redirect_hold();
        assert_reset();
        release_reset();
        applyStimulus_free(4);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        vectors++;
        if (state !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL redir_enter_hold state got %b want 01", state);
        end
        drive(1'b1, 1'b0, 1'b1, 32'h0000_0103);
        tick();
        vectors++;
        if ({imem_addr, if_id_valid, if_id_instr, state} !== {32'h100, 1'b0, NOP, 2'b10}) begin
            miscompares++;
            $display("[TB] FAIL redir_flush got addr=%h v=%b instr=%h state=%b want 00000100 0 %h 10",
                     imem_addr, if_id_valid, if_id_instr, state, NOP);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        vectors++;
        if ({imem_addr, if_id_valid, if_id_instr, state} !== {32'h104, 1'b0, NOP, 2'b00}) begin
            miscompares++;
            $display("[TB] FAIL redir_bubble got addr=%h v=%b instr=%h state=%b want 00000104 0 %h 00",
                     imem_addr, if_id_valid, if_id_instr, state, NOP);
        end
        tick();
        vectors++;
        if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h100, 32'h100 ^ KEY}) begin
            miscompares++;
            $display("[TB] FAIL redir_target got v=%b pc=%h instr=%h want pc=00000100",
                     if_id_valid, if_id_pc, if_id_instr);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("[TB] FAIL redir_model cycle %0d got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        seen;
        logic [31:0] first_pc;
        seen     = 1'b0;
        first_pc = 32'h0;
        assert_reset();
        release_reset();
        applyStimulus_free(3);
        drive(1'b1, 1'b1, 1'b1, 32'h200);
        tick();
        drive(1'b1, 1'b1, 1'b1, 32'h300);
        tick();
        vectors++;
        if ({state, imem_addr, if_id_valid} !== {2'b10, 32'h300, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_flush got state=%b addr=%h v=%b want 10 00000300 0",
                     state, imem_addr, if_id_valid);
        end
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if (if_id_valid && (if_id_pc >= 32'h200) && (if_id_pc < 32'h300)) begin
                miscompares++;
                $display("[TB] FAIL b2b_stale_path got pc=%h want none from 0x200 path", if_id_pc);
            end
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("[TB] FAIL b2b_model cycle %0d got %h want %h", i, dut_vec(), model_vec());
            end
            if (if_id_valid && !seen) begin
                seen     = 1'b1;
                first_pc = if_id_pc;
            end
        end
        vectors++;
        if (!seen || (first_pc !== 32'h300)) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_valid got seen=%b pc=%h want 00000300", seen, first_pc);
        end
    endtask

    task automatic test_reset_in_flush();
        logic [115:0] want;
        want = {RESET_PC, 32'h0, NOP, 1'b0, 2'b00, 1'b0, 16'h0};
        assert_reset();
        release_reset();
        applyStimulus_free(3);
        drive(1'b1, 1'b1, 1'b1, 32'h400);
        tick();
        vectors++;
        if (state !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL rstflush_in_flush state got %b want 10", state);
        end
        assert_reset();
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("[TB] FAIL rstflush_async got %h want %h", dut_vec(), want);
        end
        release_reset();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) begin
                vectors++;
                if ({if_id_valid, if_id_pc} !== {1'b1, RESET_PC}) begin
                    miscompares++;
                    $display("[TB] FAIL rstflush_first_pc got v=%b pc=%h want pc=%h",
                             if_id_valid, if_id_pc, RESET_PC);
                end
            end
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("[TB] FAIL rstflush_model cycle %0d got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        assert_reset();
        release_reset();
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        tick();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        vectors++;
        if (imem_addr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL rand_pc_wrap got %h want 00000000", imem_addr);
        end
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0, $urandom);
            tick();
            vectors++;
            if (dut_vec() !== model_vec()) begin
                miscompares++;
                $display("[TB] FAIL rand_model cycle %0d got %h want %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_stall_saturation();
        assert_reset();
        release_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (65534) tick();
        vectors++;
        if (stall_cnt !== 16'hFFFE) begin
            miscompares++;
            $display("[TB] FAIL sat_below got %h want FFFE", stall_cnt);
        end
        tick();
        vectors++;
        if (stall_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL sat_reach got %h want FFFF", stall_cnt);
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (3) tick();
        vectors++;
        if (stall_cnt !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL sat_hold got %h want FFFF", stall_cnt);
        end
        vectors++;
        if (dut_vec() !== model_vec()) begin
            miscompares++;
            $display("[TB] FAIL sat_model got %h want %h", dut_vec(), model_vec());
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        mem_rdata = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        model_reset();
        $display("[TB] fetch_stage_ctrl bench start");
        test_reset();
        test_free_run();
        test_stall_no_issue();
        test_skid_pc_write();
        test_redirect_hold();
        test_back_to_back();
        test_reset_in_flush();
        test_random();
        test_stall_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
